// File: rtl/demux_stream.sv
// Registered valid/ready demux: one word per cycle to one of CHANNELS one-entry slots, optional bit reversal.
// Latency 1 cycle. in_ready drops only when the targeted slot is full and its consumer is not draining it.
module demux_stream #(
   parameter int WIDTH    = 13,
   parameter int CHANNELS = 7,
   localparam int SELW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [WIDTH-1:0]          in_data,
   input  logic [SELW-1:0]           in_sel,
   input  logic                      in_rev,
   input  logic                      in_valid,
   output logic                      in_ready,
   output logic [CHANNELS*WIDTH-1:0] out_data,
   output logic [CHANNELS-1:0]       out_valid,
   input  logic [CHANNELS-1:0]       out_ready,
   output logic [7:0]                drop_count
);

   localparam int NSLOT = 1 << SELW;
   localparam logic [SELW:0] CH_LIM = (SELW+1)'(CHANNELS);

   logic [WIDTH-1:0]    data_q [CHANNELS];
   logic [WIDTH-1:0]    data_d [CHANNELS];
   logic [CHANNELS-1:0] valid_q, valid_d;
   logic [7:0]          drop_q, drop_d;

   logic [NSLOT-1:0]    full_pad, drain_pad;
   logic                in_range, accept;
   logic [WIDTH-1:0]    rev_word, word;

   // Status vectors padded to a power of two so any select value indexes safely.
   always_comb begin
      full_pad                  = '0;
      drain_pad                 = '0;
      full_pad[CHANNELS-1:0]    = valid_q;
      drain_pad[CHANNELS-1:0]   = out_ready;
      in_range                  = {1'b0, in_sel} < CH_LIM;
      in_ready                  = !in_range || !full_pad[in_sel] || drain_pad[in_sel];
   end

   always_comb begin
      rev_word = '0;
      for (int b = 0; b < WIDTH; b++) begin
         rev_word[b] = in_data[WIDTH-1-b];
      end
      word = in_rev ? rev_word : in_data;
   end

   always_comb begin
      accept  = in_valid && in_ready;
      valid_d = valid_q & ~out_ready;
      data_d  = data_q;
      drop_d  = drop_q;
      if (accept && !in_range && drop_q != 8'hFF) begin
         drop_d = drop_q + 8'd1;
      end
      // A load overrides a same-cycle drain, giving back-to-back words with no bubble.
      for (int k = 0; k < CHANNELS; k++) begin
         if (accept && in_range && in_sel == SELW'(k)) begin
            data_d[k]  = word;
            valid_d[k] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < CHANNELS; k++) begin
            data_q[k] <= '0;
         end
         valid_q <= '0;
         drop_q  <= '0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
         drop_q  <= drop_d;
      end
   end

   always_comb begin
      out_data = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         out_data[k*WIDTH +: WIDTH] = data_q[k];
      end
   end

   assign out_valid  = valid_q;
   assign drop_count = drop_q;

endmodule

// File: tb/tb_demux_stream.sv
// Directed, table-driven bench for demux_stream at WIDTH=13, CHANNELS=7.
module tb_demux_stream;

   localparam int W = 13;
   localparam int C = 7;

   logic            clk = 1'b0;
   logic            reset;
   logic [W-1:0]    in_data;
   logic [2:0]      in_sel;
   logic            in_rev;
   logic            in_valid;
   logic            in_ready;
   logic [C*W-1:0]  out_data;
   logic [C-1:0]    out_valid;
   logic [C-1:0]    out_ready;
   logic [7:0]      drop_count;

   int errors = 0;
   int checks = 0;

   demux_stream #(.WIDTH(W), .CHANNELS(C)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_data    (in_data),
      .in_sel     (in_sel),
      .in_rev     (in_rev),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .drop_count (drop_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] dat;
      logic [2:0]   sel;
      logic         rev;
      logic         vld;
      logic [C-1:0] rdy;
      logic         exp_rdy;
      logic [C-1:0] exp_vld;
      int           chk_ch;
      logic [W-1:0] exp_dat;
      logic [7:0]   exp_drop;
   } vec_t;

   vec_t vecs [12];

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [W-1:0] ch(input int k);
      return out_data[k*W +: W];
   endfunction

   // Entered just after a rising edge; returns just after the next one.
   task automatic apply(input vec_t v, input int idx);
      in_data   = v.dat;
      in_sel    = v.sel;
      in_rev    = v.rev;
      in_valid  = v.vld;
      out_ready = v.rdy;
      #1;
      chk($sformatf("vec%0d in_ready", idx), 128'(in_ready), 128'(v.exp_rdy));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d out_valid", idx), 128'(out_valid), 128'(v.exp_vld));
      chk($sformatf("vec%0d ch%0d data", idx, v.chk_ch), 128'(ch(v.chk_ch)), 128'(v.exp_dat));
      chk($sformatf("vec%0d drop_count", idx), 128'(drop_count), 128'(v.exp_drop));
   endtask

   initial begin
      logic [W-1:0] w;
      logic [C*W-1:0] exp_bus;

      //            dat      sel   rev   vld   rdy         erdy  evld        ch  edat     edrop
      vecs[0]  = '{13'h0001, 3'd3, 1'b0, 1'b1, 7'b0000000, 1'b1, 7'b0001000, 3, 13'h0001, 8'd0};
      vecs[1]  = '{13'h0000, 3'd3, 1'b0, 1'b0, 7'b0001000, 1'b1, 7'b0000000, 3, 13'h0001, 8'd0};
      vecs[2]  = '{13'h0001, 3'd0, 1'b1, 1'b1, 7'b1111111, 1'b1, 7'b0000001, 0, 13'h1000, 8'd0};
      vecs[3]  = '{13'h0001, 3'd0, 1'b0, 1'b1, 7'b1111111, 1'b1, 7'b0000001, 0, 13'h0001, 8'd0};
      vecs[4]  = '{13'h1555, 3'd2, 1'b0, 1'b1, 7'b0000000, 1'b1, 7'b0000101, 2, 13'h1555, 8'd0};
      vecs[5]  = '{13'h1234, 3'd2, 1'b0, 1'b1, 7'b0000000, 1'b0, 7'b0000101, 2, 13'h1555, 8'd0};
      vecs[6]  = '{13'h0000, 3'd5, 1'b0, 1'b0, 7'b0000000, 1'b1, 7'b0000101, 5, 13'h0000, 8'd0};
      vecs[7]  = '{13'h0ABC, 3'd2, 1'b0, 1'b1, 7'b0000100, 1'b1, 7'b0000101, 2, 13'h0ABC, 8'd0};
      vecs[8]  = '{13'h1FFF, 3'd6, 1'b1, 1'b1, 7'b0000101, 1'b1, 7'b1000000, 6, 13'h1FFF, 8'd0};
      vecs[9]  = '{13'h0B0A, 3'd1, 1'b1, 1'b1, 7'b0000000, 1'b1, 7'b1000010, 1, 13'h0A1A, 8'd0};
      vecs[10] = '{13'h1111, 3'd7, 1'b0, 1'b1, 7'b0000000, 1'b1, 7'b1000010, 6, 13'h1FFF, 8'd1};
      vecs[11] = '{13'h0000, 3'd7, 1'b0, 1'b0, 7'b1111111, 1'b1, 7'b0000000, 1, 13'h0A1A, 8'd1};

      reset = 1'b1; in_data = '0; in_sel = '0; in_rev = 1'b0; in_valid = 1'b0; out_ready = '0;
      #1;
      chk("reset out_valid", 128'(out_valid), 128'(0));
      chk("reset out_data", 128'(out_data), 128'(0));
      chk("reset drop_count", 128'(drop_count), 128'(0));
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      for (int s = 0; s < 8; s++) begin
         in_sel = 3'(s);
         #0;
         chk($sformatf("reset in_ready sel%0d", s), 128'(in_ready), 128'(1));
      end

      apply(vecs[0], 0);
      exp_bus = '0;
      exp_bus[3*W +: W] = 13'h0001;
      chk("single send full bus", 128'(out_data), 128'(exp_bus));
      for (int i = 1; i < 12; i++) apply(vecs[i], i);

      // Out-of-range flood: drop_count starts at 1 and must saturate.
      in_sel = 3'd7; in_valid = 1'b1; in_data = 13'h0F0F; out_ready = '0;
      for (int i = 0; i < 300; i++) begin
         #1;
         chk($sformatf("oor%0d in_ready", i), 128'(in_ready), 128'(1));
         @(posedge clk);
         #1;
         chk($sformatf("oor%0d out_valid", i), 128'(out_valid), 128'(0));
      end
      chk("oor drop_count saturated", 128'(drop_count), 128'(255));

      // Round-robin stream with all consumers ready.
      out_ready = '1;
      for (int i = 0; i < 70; i++) begin
         w = 13'(i * 397 + 11);
         in_sel = 3'(i % C); in_data = w; in_rev = 1'b0; in_valid = 1'b1;
         #1;
         chk($sformatf("stream%0d in_ready", i), 128'(in_ready), 128'(1));
         @(posedge clk);
         #1;
         chk($sformatf("stream%0d out_valid", i), 128'(out_valid), 128'(7'b1 << (i % C)));
         chk($sformatf("stream%0d data", i), 128'(ch(i % C)), 128'(w));
      end
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("stream drained", 128'(out_valid), 128'(0));

      // Build state: drop_count=5, channels 1 and 4 full, then async reset between edges.
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0; out_ready = '0;
      in_sel = 3'd7; in_valid = 1'b1;
      repeat (5) begin
         @(posedge clk);
         #1;
      end
      in_sel = 3'd1; in_data = 13'h0111;
      @(posedge clk);
      #1;
      in_sel = 3'd4; in_data = 13'h0444;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("prereset drop_count", 128'(drop_count), 128'(5));
      chk("prereset out_valid", 128'(out_valid), 128'(7'b0010010));
      chk("prereset ch4", 128'(ch(4)), 128'(13'h0444));
      #3;
      reset = 1'b1;
      #1;
      chk("async reset out_valid", 128'(out_valid), 128'(0));
      chk("async reset out_data", 128'(out_data), 128'(0));
      chk("async reset drop_count", 128'(drop_count), 128'(0));
      @(posedge clk);
      #1;
      reset = 1'b0;
      in_sel = 3'd1; in_data = 13'h0055; in_valid = 1'b1;
      #1;
      chk("post reset in_ready", 128'(in_ready), 128'(1));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("post reset out_valid", 128'(out_valid), 128'(7'b0000010));
      chk("post reset ch1", 128'(ch(1)), 128'(13'h0055));
      chk("post reset ch4", 128'(ch(4)), 128'(0));
      chk("post reset drop_count", 128'(drop_count), 128'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
